lmg_movelist_sequencer: RTL and testbench

//  Sequences one legal-move-generation pass: resets the LMG, waits for its done flag, pops 152-bit FIFO words and

---
 rtl/chess_ctrl_pkg.sv | 22 ++
 rtl/lmg_word_unpacker.sv | 44 ++++
 rtl/lmg_movelist_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lmg_movelist_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_ctrl_pkg.sv
// Shared constants and state encoding for the legal-move-list sequencer.
package chess_ctrl_pkg;

    localparam int LMG_SLOTS  = 8;
    localparam int LMG_SLOT_W = 19;
    localparam int LMG_MOVE_W = 18;
    localparam int LMG_WORD_W = LMG_SLOTS * LMG_SLOT_W;
    localparam int LIST_BASE  = 16;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_LMG_RST,
        SEQ_WAIT_DONE,
        SEQ_POP,
        SEQ_LATCH,
        SEQ_SCAN,
        SEQ_HEADER,
        SEQ_TERM,
        SEQ_DONE
    } seqState_e;

endpackage

// File: rtl/lmg_word_unpacker.sv
// Holds one captured LMG FIFO word and presents its move slots one at a time.
module lmg_word_unpacker
    import chess_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [LMG_WORD_W-1:0] wordIn,
    output logic [LMG_MOVE_W-1:0] slotMove,
    output logic                  slotValid,
    output logic                  lastSlot,
    output logic                  allInvalid
);

    logic [LMG_WORD_W-1:0] wordReg;
    logic [2:0]            slotIdx;
    logic [LMG_SLOT_W-1:0] curSlot;

    always_ff @(posedge clk) begin
        if (load) wordReg <= wordIn;
    end

    always_ff @(posedge clk) begin
        if (reset)        slotIdx <= '0;
        else if (load)    slotIdx <= '0;
        else if (advance) slotIdx <= slotIdx + 3'd1;
    end

    // A word with every invalid flag set is the LMG's end-of-list marker.
    always_comb begin
        curSlot    = '0;
        allInvalid = 1'b1;
        for (int k = 0; k < LMG_SLOTS; k++) begin
            if (slotIdx == 3'(k)) curSlot = wordReg[k*LMG_SLOT_W +: LMG_SLOT_W];
            allInvalid = allInvalid & wordReg[k*LMG_SLOT_W + LMG_MOVE_W];
        end
    end

    assign slotMove  = curSlot[LMG_MOVE_W-1:0];
    assign slotValid = ~curSlot[LMG_MOVE_W];
    assign lastSlot  = (slotIdx == 3'(LMG_SLOTS - 1));

endmodule

// File: rtl/lmg_movelist_sequencer.sv
// Runs one legal-move-generation pass and writes the compacted move list,
// its count/overflow header and a zero terminator into the move-list RAM.
module lmg_movelist_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int LIST_BASE  = chess_ctrl_pkg::LIST_BASE,
    parameter int MAX_MOVES  = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [7:0]                            move_count,
    output logic                                  overflow,
    output logic                                  lmg_reset,
    input  logic                                  lmg_done,
    input  logic                                  lmg_fifo_empty,
    output logic                                  lmg_rden,
    input  logic [chess_ctrl_pkg::LMG_WORD_W-1:0] lmg_fifo_out,
    output logic                                  ram_wren,
    output logic [ADDR_WIDTH-1:0]                 ram_wraddr,
    output logic [DATA_WIDTH-1:0]                 ram_data
);
    import chess_ctrl_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] HEADER_ADDR = ADDR_WIDTH'(LIST_BASE);
    localparam logic [ADDR_WIDTH-1:0] MOVE_BASE   = ADDR_WIDTH'(LIST_BASE + 1);
    localparam logic [7:0]            MAX_CNT     = 8'(MAX_MOVES);

    seqState_e              state, stateNext;
    logic                   rstCnt, rstCntNext;
    logic                   busyNext, doneNext, ovfNext;
    logic                   lmgRstNext, rdenNext, wrenNext;
    logic [7:0]             countNext;
    logic [ADDR_WIDTH-1:0]  addrNext;
    logic [DATA_WIDTH-1:0]  dataNext;
    logic                   wordLoad, slotAdvance;
    logic [LMG_MOVE_W-1:0]  slotMove;
    logic                   slotValid, lastSlot, allInvalid;

    function automatic logic [DATA_WIDTH-1:0] headerWord(input logic ovf, input logic [7:0] cnt);
        logic [DATA_WIDTH-1:0] w;
        w                 = '0;
        w[DATA_WIDTH-1]   = ovf;
        w[7:0]            = cnt;
        return w;
    endfunction

    lmg_word_unpacker unpacker (
        .clk        (clk),
        .reset      (reset),
        .load       (wordLoad),
        .advance    (slotAdvance),
        .wordIn     (lmg_fifo_out),
        .slotMove   (slotMove),
        .slotValid  (slotValid),
        .lastSlot   (lastSlot),
        .allInvalid (allInvalid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            rstCnt     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
            overflow   <= 1'b0;
            lmg_reset  <= 1'b0;
            lmg_rden   <= 1'b0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= '0;
        end else begin
            state      <= stateNext;
            rstCnt     <= rstCntNext;
            busy       <= busyNext;
            done       <= doneNext;
            move_count <= countNext;
            overflow   <= ovfNext;
            lmg_reset  <= lmgRstNext;
            lmg_rden   <= rdenNext;
            ram_wren   <= wrenNext;
            ram_wraddr <= addrNext;
            ram_data   <= dataNext;
        end
    end

    // Each state's action is registered, so it appears on the ports during the following cycle.
    always_comb begin
        stateNext   = state;
        rstCntNext  = rstCnt;
        busyNext    = busy;
        doneNext    = done;
        countNext   = move_count;
        ovfNext     = overflow;
        lmgRstNext  = 1'b0;
        rdenNext    = 1'b0;
        wrenNext    = 1'b0;
        addrNext    = ram_wraddr;
        dataNext    = ram_data;
        wordLoad    = 1'b0;
        slotAdvance = 1'b0;

        case (state)
            SEQ_IDLE, SEQ_DONE: begin
                if (start) begin
                    stateNext  = SEQ_LMG_RST;
                    rstCntNext = 1'b0;
                    countNext  = '0;
                    ovfNext    = 1'b0;
                    doneNext   = 1'b0;
                    busyNext   = 1'b1;
                    lmgRstNext = 1'b1;
                end
            end
            SEQ_LMG_RST: begin
                if (!rstCnt) begin
                    rstCntNext = 1'b1;
                    lmgRstNext = 1'b1;
                end else begin
                    stateNext  = SEQ_WAIT_DONE;
                end
            end
            SEQ_WAIT_DONE: begin
                if (lmg_done) begin
                    if (!lmg_fifo_empty) begin
                        stateNext = SEQ_POP;
                        rdenNext  = 1'b1;
                    end else begin
                        stateNext = SEQ_HEADER;
                    end
                end
            end
            SEQ_POP: stateNext = SEQ_LATCH;
            SEQ_LATCH: begin
                wordLoad  = 1'b1;
                stateNext = SEQ_SCAN;
            end
            SEQ_SCAN: begin
                if (allInvalid) begin
                    stateNext = SEQ_HEADER;
                end else begin
                    slotAdvance = 1'b1;
                    if (slotValid) begin
                        if (move_count < MAX_CNT) begin
                            wrenNext  = 1'b1;
                            addrNext  = MOVE_BASE + ADDR_WIDTH'(move_count);
                            dataNext  = DATA_WIDTH'(slotMove);
                            countNext = move_count + 8'd1;
                        end else begin
                            ovfNext   = 1'b1;
                        end
                    end
                    if (lastSlot) begin
                        if (!lmg_fifo_empty) begin
                            stateNext = SEQ_POP;
                            rdenNext  = 1'b1;
                        end else begin
                            stateNext = SEQ_HEADER;
                        end
                    end
                end
            end
            SEQ_HEADER: begin
                wrenNext  = 1'b1;
                addrNext  = HEADER_ADDR;
                dataNext  = headerWord(overflow, move_count);
                stateNext = SEQ_TERM;
            end
            SEQ_TERM: begin
                wrenNext  = 1'b1;
                addrNext  = MOVE_BASE + ADDR_WIDTH'(move_count);
                dataNext  = '0;
                stateNext = SEQ_DONE;
                doneNext  = 1'b1;
                busyNext  = 1'b0;
            end
            default: stateNext = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lmg_movelist_sequencer.sv
// Bench for the move-list sequencer: LMG/FIFO/RAM models plus a list-level reference model.
module tb_lmg_movelist_sequencer;

    localparam int WW = 152;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, overflow, lmg_reset, lmg_rden, ram_wren;
    logic [7:0]    move_count;
    logic [14:0]   ram_wraddr;
    logic [31:0]   ram_data;
    logic          lmg_done = 1'b0;
    logic          lmg_fifo_empty = 1'b1;
    logic [WW-1:0] lmg_fifo_out = '0;

    lmg_movelist_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .move_count     (move_count),
        .overflow       (overflow),
        .lmg_reset      (lmg_reset),
        .lmg_done       (lmg_done),
        .lmg_fifo_empty (lmg_fifo_empty),
        .lmg_rden       (lmg_rden),
        .lmg_fifo_out   (lmg_fifo_out),
        .ram_wren       (ram_wren),
        .ram_wraddr     (ram_wraddr),
        .ram_data       (ram_data)
    );

    always #5 clk = ~clk;

    // Words the LMG will produce on its next reset, set up by the stimulus.
    logic [WW-1:0] stage [64];
    int stageLen = 0;
    int lmgDelay = 3;
    int passId = 0;

    // State owned by the LMG/FIFO/RAM model process.
    int rdIdx = 0, dcnt = 0, writeCnt = 0, rstRun = 0, lastPulse = 0, pulseCnt = 0;
    logic [31:0] mem [1024];
    int memPass [1024] = '{default: -1};

    always @(negedge clk) begin
        if (ram_wren) begin
            writeCnt++;
            if (ram_wraddr[14:10] == 5'd0) begin
                mem[ram_wraddr[9:0]]     = ram_data;
                memPass[ram_wraddr[9:0]] = passId;
            end
        end
        if (lmg_reset) begin
            rstRun++;
            rdIdx    = 0;
            lmg_done = 1'b0;
            dcnt     = lmgDelay;
        end else begin
            if (rstRun > 0) begin
                lastPulse = rstRun;
                pulseCnt++;
                rstRun = 0;
            end
            if (dcnt > 0) dcnt--;
            else lmg_done = 1'b1;
        end
        if (lmg_rden && rdIdx < stageLen) begin
            lmg_fifo_out = stage[rdIdx];
            rdIdx++;
        end
        lmg_fifo_empty = (rdIdx >= stageLen);
    end

    int vectors = 0, miscompares = 0;
    int passStartCnt = 0, pulseStart = 0;
    logic [WW-1:0] allInvWord;
    logic [31:0] refMoves [$];
    bit refOvf;

    typedef struct {
        int          kind;
        int          expCount;
        bit          expOvf;
        logic [31:0] expHeader;
        int          lastAddr;
        logic [31:0] lastVal;
        int          termAddr;
    } vec_t;
    vec_t tbl [4];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ramAt(input int a);
        if (memPass[a] == passId) return mem[a];
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic [WW-1:0] setSlot(input logic [WW-1:0] w, input int k, input logic [17:0] mv);
        logic [WW-1:0] r;
        r               = w;
        r[19*k +: 18]   = mv;
        r[19*k + 18]    = 1'b0;
        return r;
    endfunction

    // Reference: moves listed in FIFO order until an all-invalid word or the FIFO runs dry,
    // capped at 255 entries with the excess flagged as overflow.
    task automatic buildRef();
        int nValid;
        refMoves.delete();
        refOvf = 1'b0;
        for (int w = 0; w < stageLen; w++) begin
            nValid = 0;
            for (int k = 0; k < 8; k++) if (!stage[w][19*k + 18]) nValid++;
            if (nValid == 0) break;
            for (int k = 0; k < 8; k++) begin
                if (!stage[w][19*k + 18]) begin
                    if (refMoves.size() < 255) refMoves.push_back(32'(stage[w][19*k +: 18]));
                    else refOvf = 1'b1;
                end
            end
        end
    endtask

    task automatic loadKind(input int kind);
        case (kind)
            1: begin
                stage[0] = setSlot(allInvWord, 0, 18'h00A51);
                stage[1] = allInvWord;
                stageLen = 2;
            end
            2, 4: begin
                int nw;
                nw = (kind == 2) ? 3 : 33;
                for (int w = 0; w < nw; w++) begin
                    stage[w] = allInvWord;
                    for (int k = 0; k < 8; k++) stage[w] = setSlot(stage[w], k, 18'(w*8 + k + 1));
                end
                stage[nw] = allInvWord;
                stageLen  = nw + 1;
            end
            default: begin
                stage[0] = allInvWord;
                stageLen = 1;
            end
        endcase
    endtask

    task automatic startPass();
        passId++;
        passStartCnt = writeCnt;
        pulseStart   = pulseCnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            step();
            c++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s done timeout: done=%b after %0d cycles, required 1", tag, done, c);
        end
    endtask

    task automatic checkPass(input string tag);
        int n;
        buildRef();
        n = refMoves.size();
        check({tag, " move_count"}, 32'(move_count), 32'(n));
        check({tag, " overflow"}, 32'(overflow), 32'(refOvf));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " header"}, ramAt(16), {refOvf, 23'b0, 8'(n)});
        for (int i = 0; i < n; i++)
            check($sformatf("%s move[%0d]", tag, 17 + i), ramAt(17 + i), refMoves[i]);
        check({tag, " terminator"}, ramAt(17 + n), 32'd0);
        check({tag, " write count"}, 32'(writeCnt - passStartCnt), 32'(n + 2));
        check({tag, " lmg_reset width"}, 32'(lastPulse), 32'd2);
        check({tag, " lmg_reset pulses"}, 32'(pulseCnt - pulseStart), 32'd1);
    endtask

    initial begin
        allInvWord = '0;
        for (int k = 0; k < 8; k++) allInvWord[19*k + 18] = 1'b1;

        tbl[0] = '{1,   1, 1'b0, 32'h0000_0001, 17, 32'h0000_0A51, 18};
        tbl[1] = '{2,  24, 1'b0, 32'h0000_0018, 40, 32'h0000_0018, 41};
        tbl[2] = '{3,   0, 1'b0, 32'h0000_0000, 16, 32'h0000_0000, 17};
        tbl[3] = '{4, 255, 1'b1, 32'h8000_00FF, 271, 32'h0000_00FF, 272};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset move_count", 32'(move_count), 0);
        check("reset overflow", 32'(overflow), 0);
        check("reset lmg_reset", 32'(lmg_reset), 0);
        check("reset lmg_rden", 32'(lmg_rden), 0);
        check("reset ram_wren", 32'(ram_wren), 0);
        check("reset ram_wraddr", 32'(ram_wraddr), 0);
        check("reset ram_data", ram_data, 0);

        // start in the same cycle as reset must not begin a pass
        start = 1'b1;
        step();
        start = 1'b0;
        check("start+reset busy", 32'(busy), 0);
        check("start+reset lmg_reset", 32'(lmg_reset), 0);
        reset = 1'b0;
        step();

        for (int t = 0; t < 4; t++) begin
            string tag;
            tag = $sformatf("table%0d", tbl[t].kind);
            loadKind(tbl[t].kind);
            lmgDelay = 3;
            startPass();
            waitDone(tag, 2000);
            check({tag, " count"}, 32'(move_count), 32'(tbl[t].expCount));
            check({tag, " ovf"}, 32'(overflow), 32'(tbl[t].expOvf));
            check({tag, " hdr"}, ramAt(16), tbl[t].expHeader);
            check({tag, " last"}, ramAt(tbl[t].lastAddr), tbl[t].lastVal);
            check({tag, " term"}, ramAt(tbl[t].termAddr), 32'd0);
            checkPass(tag);
        end

        // reset in SCAN after three writes, then a clean restart
        loadKind(2);
        startPass();
        begin
            int c;
            c = 0;
            while (writeCnt - passStartCnt < 3 && c < 500) begin
                step();
                c++;
            end
            check("abort three writes seen", 32'(writeCnt - passStartCnt), 32'd3);
        end
        reset = 1'b1;
        step();
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort ram_wren", 32'(ram_wren), 0);
        check("abort move_count", 32'(move_count), 0);
        check("abort lmg_rden", 32'(lmg_rden), 0);
        reset = 1'b0;
        step();
        startPass();
        check("restart lmg_reset", 32'(lmg_reset), 1);
        waitDone("restart", 2000);
        checkPass("restart");

        // start while busy is ignored
        loadKind(2);
        startPass();
        repeat (12) step();
        check("busy mid-pass", 32'(busy), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        waitDone("busy-start", 2000);
        checkPass("busy-start");

        // start from DONE begins a fresh pass
        repeat (2) step();
        check("done held", 32'(done), 1);
        loadKind(1);
        startPass();
        check("done drop", 32'(done), 0);
        check("busy rise", 32'(busy), 1);
        waitDone("from-done", 2000);
        checkPass("from-done");

        // randomized passes, including empty FIFOs and runs ending without a terminator
        for (int r = 0; r < 24; r++) begin
            int len;
            logic [WW-1:0] word;
            len = $urandom_range(0, 6);
            for (int w = 0; w < len; w++) begin
                word = allInvWord;
                for (int k = 0; k < 8; k++)
                    if ($urandom_range(0, 9) < 6) word = setSlot(word, k, 18'($urandom));
                stage[w] = word;
            end
            if (len > 1 && $urandom_range(0, 1) == 1) stage[len-1] = allInvWord;
            stageLen = len;
            lmgDelay = $urandom_range(0, 6);
            startPass();
            waitDone($sformatf("rand%0d", r), 2000);
            checkPass($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
